// File: rtl/mem_msg_pkg.sv
// Shared message definitions for the memreq/memresp interface: type codes, field widths
// and byte-lane helpers used when a sub-line access is placed in a 128-bit line.
package mem_msg_pkg;

  localparam int unsigned TypeW     = 3;
  localparam int unsigned OpaqueW   = 8;
  localparam int unsigned AddrW     = 32;
  localparam int unsigned LenW      = 4;
  localparam int unsigned DataW     = 128;
  localparam int unsigned LineBytes = 16;

  typedef enum logic [TypeW-1:0] {
    MemRead  = 3'd0,
    MemWrite = 3'd1,
    MemInit  = 3'd2
  } mem_type_e;

  // Byte lanes 0..n-1 where n = 16 for len==0, else len.
  function automatic logic [LineBytes-1:0] len_mask(input logic [LenW-1:0] len);
    if (len == '0) begin
      return '1;
    end
    return (LineBytes'(1) << len) - LineBytes'(1);
  endfunction

  // Lanes offset..offset+n-1; lanes past the line end fall off the top (truncation).
  function automatic logic [LineBytes-1:0] byte_mask(input logic [LenW-1:0] len,
                                                     input logic [3:0]      off);
    logic [2*LineBytes-1:0] wide;
    wide = {{LineBytes{1'b0}}, len_mask(len)} << off;
    return LineBytes'(wide);
  endfunction

  // Widen a byte-lane mask to a bit mask over the whole line.
  function automatic logic [DataW-1:0] expand_mask(input logic [LineBytes-1:0] be);
    logic [DataW-1:0] m;
    m = '0;
    for (int b = 0; b < LineBytes; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/blocking_mem_responder_if.sv
// Request/response channel between the blocking cache (master) and its memory (slave).
interface blocking_mem_responder_if;
  import mem_msg_pkg::*;

  logic               memreq_val;
  logic               memreq_rdy;
  logic [TypeW-1:0]   memreq_type;
  logic [OpaqueW-1:0] memreq_opaque;
  logic [AddrW-1:0]   memreq_addr;
  logic [LenW-1:0]    memreq_len;
  logic [DataW-1:0]   memreq_data;

  logic               memresp_val;
  logic               memresp_rdy;
  logic [TypeW-1:0]   memresp_type;
  logic [OpaqueW-1:0] memresp_opaque;
  logic [LenW-1:0]    memresp_len;
  logic [DataW-1:0]   memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    output memresp_rdy,
    input  memreq_rdy,
    input  memresp_val, memresp_type, memresp_opaque, memresp_len, memresp_data
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_opaque, memreq_addr, memreq_len, memreq_data,
    input  memresp_rdy,
    output memreq_rdy,
    output memresp_val, memresp_type, memresp_opaque, memresp_len, memresp_data
  );

endinterface

// File: rtl/mem_line_array.sv
// Backing store: p_num_lines x 128-bit lines, byte-enabled synchronous write,
// combinational read. Contents are deliberately not reset.
module mem_line_array
  import mem_msg_pkg::*;
#(
  parameter int unsigned p_num_lines = 64,
  localparam int unsigned IdxW = $clog2(p_num_lines)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [IdxW-1:0]      wr_idx,
  input  logic [LineBytes-1:0] wr_be,
  input  logic [DataW-1:0]     wr_data,
  input  logic [IdxW-1:0]      rd_idx,
  output logic [DataW-1:0]     rd_data
);

  logic [DataW-1:0] lines [p_num_lines];

  // Update only the enabled byte lanes of the addressed line.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < LineBytes; b++) begin
        if (wr_be[b]) begin
          lines[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = lines[rd_idx];

endmodule

// File: rtl/blocking_mem_responder.sv
// Single-outstanding memory responder: accepts one request, performs the array access at
// accept time, waits p_latency cycles, then presents the response until it is taken.
module blocking_mem_responder
  import mem_msg_pkg::*;
#(
  parameter int unsigned p_num_lines = 64,
  parameter int unsigned p_latency   = 2
) (
  input logic                     clk,
  input logic                     reset,
  blocking_mem_responder_if.slave mem
);

  localparam int unsigned IdxW = $clog2(p_num_lines);
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               req_rdy_q;
  logic               resp_val_q;
  logic [TypeW-1:0]   resp_type_q;
  logic [OpaqueW-1:0] resp_opaque_q;
  logic [LenW-1:0]    resp_len_q;
  logic [DataW-1:0]   resp_data_q;

  logic [IdxW-1:0]      line_idx;
  logic [3:0]           offset;
  logic [DataW-1:0]     line_rd;
  logic [DataW-1:0]     rd_data;
  logic [DataW-1:0]     wr_data;
  logic [LineBytes-1:0] wr_be;
  logic                 accept;
  logic                 is_store;
  logic                 wr_en;
  logic                 unused_addr_bits;

  // Address bits above the line index alias onto the same line.
  assign line_idx         = mem.memreq_addr[4+IdxW-1:4];
  assign offset           = mem.memreq_addr[3:0];
  assign unused_addr_bits = ^mem.memreq_addr[AddrW-1:4+IdxW];

  assign accept   = mem.memreq_val && req_rdy_q;
  // Illegal type codes fall through to the read path and never modify storage.
  assign is_store = (mem.memreq_type == MemWrite) || (mem.memreq_type == MemInit);
  assign wr_en    = accept && is_store;

  // Right-justified request data is shifted up to its byte offset within the line.
  assign wr_be   = byte_mask(mem.memreq_len, offset);
  assign wr_data = mem.memreq_data << {offset, 3'b000};
  // Line bytes from offset are right-justified; lanes at or above n are zeroed.
  assign rd_data = (line_rd >> {offset, 3'b000}) & expand_mask(len_mask(mem.memreq_len));

  mem_line_array #(
    .p_num_lines (p_num_lines)
  ) u_lines (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (line_idx),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_idx  (line_idx),
    .rd_data (line_rd)
  );

  // Request/latency/response sequencing with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      req_rdy_q     <= 1'b0;
      resp_val_q    <= 1'b0;
      resp_type_q   <= '0;
      resp_opaque_q <= '0;
      resp_len_q    <= '0;
      resp_data_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          req_rdy_q <= 1'b1;
          if (accept) begin
            req_rdy_q     <= 1'b0;
            resp_type_q   <= mem.memreq_type;
            resp_opaque_q <= mem.memreq_opaque;
            resp_len_q    <= mem.memreq_len;
            resp_data_q   <= is_store ? '0 : rd_data;
            if (p_latency > 0) begin
              state_q <= StWait;
              cnt_q   <= CntW'(p_latency - 1);
            end else begin
              state_q    <= StResp;
              resp_val_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q    <= StResp;
            resp_val_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (mem.memresp_rdy) begin
            state_q    <= StIdle;
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem.memreq_rdy     = req_rdy_q;
  assign mem.memresp_val    = resp_val_q;
  assign mem.memresp_type   = resp_type_q;
  assign mem.memresp_opaque = resp_opaque_q;
  assign mem.memresp_len    = resp_len_q;
  assign mem.memresp_data   = resp_data_q;

endmodule

// File: tb/tb_blocking_mem_responder.sv
// Bench for blocking_mem_responder: a transaction-level model (byte array plus one pending
// response with an accept timestamp) is checked against the DUT every cycle, with directed
// literal checks and a randomized traffic phase.
module tb_blocking_mem_responder;
  import mem_msg_pkg::*;

  localparam int unsigned NL  = 64;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic reset;

  blocking_mem_responder_if mem_if ();

  blocking_mem_responder #(
    .p_num_lines (NL),
    .p_latency   (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   mmem [NL][16];
  bit           pending = 1'b0;
  bit           started = 1'b0;
  int           cyc     = 0;
  int           acc_cyc = 0;
  logic [2:0]   e_type;
  logic [7:0]   e_op;
  logic [3:0]   e_len;
  logic [127:0] e_data;

  function automatic bit rdy_exp();
    return started && !pending;
  endfunction

  function automatic bit val_exp();
    return pending && (cyc >= acc_cyc + int'(LAT));
  endfunction

  task automatic model_accept();
    int n;
    int off;
    int li;
    n       = (mem_if.memreq_len == 4'd0) ? 16 : int'(mem_if.memreq_len);
    off     = int'(mem_if.memreq_addr[3:0]);
    li      = int'((mem_if.memreq_addr >> 4) % NL);
    e_type  = mem_if.memreq_type;
    e_op    = mem_if.memreq_opaque;
    e_len   = mem_if.memreq_len;
    e_data  = '0;
    for (int i = 0; i < n; i++) begin
      if (off + i < 16) begin
        if (mem_if.memreq_type == 3'd1 || mem_if.memreq_type == 3'd2) begin
          mmem[li][off+i] = mem_if.memreq_data[8*i +: 8];
        end else begin
          e_data[8*i +: 8] = mmem[li][off+i];
        end
      end
    end
    pending = 1'b1;
    acc_cyc = cyc;
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      for (int b = 0; b < 16; b++) begin
        mmem[l][b] = 8'h00;
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending = 1'b0;
      started = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (!started) begin
        started = 1'b1;
      end else if (!pending) begin
        if (mem_if.memreq_val) model_accept();
      end else if ((cyc - 1 >= acc_cyc + int'(LAT)) && mem_if.memresp_rdy) begin
        pending = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_rdy", mem_if.memreq_rdy, 0);
      chk("rst_val", mem_if.memresp_val, 0);
      chk("rst_fields", {mem_if.memresp_type, mem_if.memresp_opaque, mem_if.memresp_len}, 0);
      chk("rst_data", mem_if.memresp_data, 0);
    end else begin
      chk("rdy", mem_if.memreq_rdy, rdy_exp());
      chk("val", mem_if.memresp_val, val_exp());
      if (val_exp()) begin
        chk("resp_type", mem_if.memresp_type, e_type);
        chk("resp_opaque", mem_if.memresp_opaque, e_op);
        chk("resp_len", mem_if.memresp_len, e_len);
        chk("resp_data", mem_if.memresp_data, e_data);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [3:0] l, input logic [127:0] d);
    int g;
    g = 0;
    while (!rdy_exp() && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!rdy_exp()) chk("send_timeout", mem_if.memreq_rdy, 1);
    mem_if.memreq_val    = 1'b1;
    mem_if.memreq_type   = t;
    mem_if.memreq_opaque = op;
    mem_if.memreq_addr   = a;
    mem_if.memreq_len    = l;
    mem_if.memreq_data   = d;
    @(posedge clk);
    @(negedge clk);
    mem_if.memreq_val = 1'b0;
  endtask

  task automatic recv(output logic [2:0] t, output logic [7:0] op, output logic [3:0] l,
                      output logic [127:0] d, output int k);
    k = 1;
    while (mem_if.memresp_val !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("resp_seen", mem_if.memresp_val, 1);
    t  = mem_if.memresp_type;
    op = mem_if.memresp_opaque;
    l  = mem_if.memresp_len;
    d  = mem_if.memresp_data;
    mem_if.memresp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_val();
    int g;
    g = 0;
    while (mem_if.memresp_val !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("wait_val", mem_if.memresp_val, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]   rt;
  logic [7:0]   rop;
  logic [3:0]   rl;
  logic [127:0] rd;
  int           rk;
  localparam logic [127:0] D1 = 128'h000F0E0D0C0B0A090807060504030201;

  initial begin
    reset                = 1'b0;
    mem_if.memreq_val    = 1'b0;
    mem_if.memreq_type   = '0;
    mem_if.memreq_opaque = '0;
    mem_if.memreq_addr   = '0;
    mem_if.memreq_len    = '0;
    mem_if.memreq_data   = '0;
    mem_if.memresp_rdy   = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // Give every line known contents.
    for (int li = 0; li < int'(NL); li++) begin
      send(3'd2, 8'(li), 32'(li * 16), 4'd0, {$urandom, $urandom, $urandom, $urandom});
      recv(rt, rop, rl, rd, rk);
    end

    send(3'd2, 8'h3A, 32'h100, 4'd0, D1);
    recv(rt, rop, rl, rd, rk);
    chk("init_type", rt, 3'd2);
    chk("init_data_zero", rd, 0);

    send(3'd0, 8'h3A, 32'h100, 4'd0, '0);
    recv(rt, rop, rl, rd, rk);
    chk("rd_latency", 32'(rk), 32'd3);
    chk("rd_type", rt, 3'd0);
    chk("rd_opaque", rop, 8'h3A);
    chk("rd_data_full", rd, D1);

    send(3'd1, 8'h11, 32'h108, 4'd4, 128'hDEADBEEF);
    recv(rt, rop, rl, rd, rk);
    send(3'd0, 8'h12, 32'h100, 4'd0, '0);
    recv(rt, rop, rl, rd, rk);
    chk("rd_after_wr", rd, 128'h000F0E0D_DEADBEEF_08070605_04030201);

    send(3'd0, 8'h13, 32'h10A, 4'd2, '0);
    recv(rt, rop, rl, rd, rk);
    chk("rd_len2", rd, 128'hDEAD);
    chk("rd_len2_len", rl, 4'd2);

    // Stall the response: outputs must hold and request pulses must be ignored.
    mem_if.memresp_rdy = 1'b0;
    send(3'd0, 8'h55, 32'h108, 4'd4, '0);
    wait_val();
    for (int i = 0; i < 5; i++) begin
      chk("hold_val", mem_if.memresp_val, 1);
      chk("hold_data", mem_if.memresp_data, 128'hDEADBEEF);
      chk("hold_opaque", mem_if.memresp_opaque, 8'h55);
      mem_if.memreq_val  = 1'(i % 2);
      mem_if.memreq_type = 3'd1;
      mem_if.memreq_addr = 32'h108;
      mem_if.memreq_data = {4{$urandom}};
      @(negedge clk);
    end
    mem_if.memreq_val  = 1'b0;
    mem_if.memresp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("resume_rdy", mem_if.memreq_rdy, 1);
    chk("resume_val", mem_if.memresp_val, 0);

    // Aliasing: 0x100 + 16*NL maps onto the same line as 0x100.
    send(3'd1, 8'h21, 32'h100 + 32'(16 * NL), 4'd4, 128'h12345678);
    recv(rt, rop, rl, rd, rk);
    send(3'd0, 8'h22, 32'h100, 4'd4, '0);
    recv(rt, rop, rl, rd, rk);
    chk("alias_data", rd, 128'h12345678);

    // Reset while waiting, then while presenting a response.
    send(3'd0, 8'h03, 32'h100, 4'd0, '0);
    #1 reset = 1'b0;
    #1 chk("rst_wait_val", mem_if.memresp_val, 0);
    chk("rst_wait_rdy", mem_if.memreq_rdy, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    mem_if.memresp_rdy = 1'b0;
    send(3'd0, 8'h04, 32'h100, 4'd0, '0);
    wait_val();
    #1 reset = 1'b0;
    #1 chk("rst_resp_val", mem_if.memresp_val, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    mem_if.memresp_rdy = 1'b1;
    repeat (10) @(negedge clk);

    // Randomized traffic, including illegal types, line crossing and ignored pulses.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      mem_if.memreq_val    = ($urandom % 4) != 0;
      mem_if.memreq_type   = (($urandom % 5) == 0) ? 3'($urandom % 8) : 3'($urandom % 3);
      mem_if.memreq_opaque = 8'($urandom);
      mem_if.memreq_addr   = $urandom;
      mem_if.memreq_len    = 4'($urandom_range(0, 15));
      mem_if.memreq_data   = {$urandom, $urandom, $urandom, $urandom};
      mem_if.memresp_rdy   = ($urandom % 4) != 0;
    end
    @(negedge clk);
    mem_if.memreq_val  = 1'b0;
    mem_if.memresp_rdy = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
